memory_arbiter: RTL and testbench

// Downstream neighbour of the request unit. Takes the registered iREN/dREN/dWEN

---
 rtl/memory_arbiter.sv | 125 ++++++++++++
 tb/tb_memory_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: fixed-priority (data over instruction) arbiter onto a single-port RAM.
// Define ARB_STATS_EN to add icount/dcount/stallcnt statistics outputs.
module memory_arbiter #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              iren_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    input  logic              dren_i,
    input  logic              dwen_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [WORD_W-1:0] dstore_i,
    output logic              iwait_o,
    output logic [WORD_W-1:0] iload_o,
    output logic              dwait_o,
    output logic [WORD_W-1:0] dload_o,
    output logic              ramren_o,
    output logic              ramwen_o,
    output logic [ADDR_W-1:0] ramaddr_o,
    output logic [WORD_W-1:0] ramstore_o,
    input  logic [WORD_W-1:0] ramload_i,
    input  logic [1:0]        ramstate_i
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       icount_o,
    output logic [31:0]       dcount_o,
    output logic [31:0]       stallcnt_o
`endif
);
    typedef enum logic [2:0] {IDLE, IGRANT, DGRANT, IDONE, DDONE} state_t;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] iload_q, iload_d, dload_q, dload_d;
    logic              dreq;

    assign dreq    = dren_i | dwen_i;
    assign iload_o = iload_q;
    assign dload_o = dload_q;

    always_comb begin
        state_d    = state_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        iwait_o    = 1'b1;
        dwait_o    = 1'b1;
        ramren_o   = 1'b0;
        ramwen_o   = 1'b0;
        ramaddr_o  = '0;
        ramstore_o = '0;
        case (state_q)
            IDLE: state_d = dreq ? DGRANT : (iren_i ? IGRANT : IDLE);
            IGRANT: begin
                ramaddr_o = iaddr_i;
                ramren_o  = iren_i;
                // A withdrawn request or RAM error abandons the access; an error retries from IDLE.
                if (!iren_i || ramstate_i == ERROR) begin
                    state_d = IDLE;
                end else if (ramstate_i == ACCESS) begin
                    state_d = IDONE;
                    iload_d = ramload_i;
                end
            end
            DGRANT: begin
                ramaddr_o  = daddr_i;
                ramstore_o = dstore_i;
                ramwen_o   = dwen_i;
                ramren_o   = dren_i & ~dwen_i;
                if (!dreq || ramstate_i == ERROR) begin
                    state_d = IDLE;
                end else if (ramstate_i == ACCESS) begin
                    state_d = DDONE;
                    dload_d = (dren_i & ~dwen_i) ? ramload_i : dload_q;
                end
            end
            IDONE: begin
                iwait_o = 1'b0;
                state_d = IDLE;
            end
            DDONE: begin
                dwait_o = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= IDLE;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] icount_q, icount_d, dcount_q, dcount_d, stallcnt_q, stallcnt_d;

    assign icount_d   = icount_q + 32'(state_d == IDONE && state_q != IDONE);
    assign dcount_d   = dcount_q + 32'(state_d == DDONE && state_q != DDONE);
    assign stallcnt_d = stallcnt_q + 32'((iren_i & iwait_o) | (dreq & dwait_o));
    assign icount_o   = icount_q;
    assign dcount_o   = dcount_q;
    assign stallcnt_o = stallcnt_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            icount_q   <= '0;
            dcount_q   <= '0;
            stallcnt_q <= '0;
        end else begin
            icount_q   <= icount_d;
            dcount_q   <= dcount_d;
            stallcnt_q <= stallcnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: per-cycle vector table for memory_arbiter plus hand sequences
// for latency and asynchronous reset mid-access.
module tb_memory_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramren, ramwen;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STATS_EN
    logic [31:0] icount, dcount, stallcnt;
`endif

    int tests = 0;
    int fails = 0;

    memory_arbiter #(.WORD_W(32), .ADDR_W(32)) dut (
        .clk_i(clk), .nrst_i(nrst),
        .iren_i(iren), .iaddr_i(iaddr),
        .dren_i(dren), .dwen_i(dwen), .daddr_i(daddr), .dstore_i(dstore),
        .iwait_o(iwait), .iload_o(iload), .dwait_o(dwait), .dload_o(dload),
        .ramren_o(ramren), .ramwen_o(ramwen), .ramaddr_o(ramaddr), .ramstore_o(ramstore),
        .ramload_i(ramload), .ramstate_i(ramstate)
`ifdef ARB_STATS_EN
        , .icount_o(icount), .dcount_o(dcount), .stallcnt_o(stallcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [31:0] ia, da, ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [3:0]  flg;
        logic [31:0] ea, es, eil, edl;
    } vec_t;

    vec_t v[$];

    // req = {iren,dren,dwen}; flg = expected {iwait,dwait,ramren,ramwen}
    function automatic void add(input logic [2:0] req, input logic [31:0] ia, da, ds,
                                input logic [1:0] rs, input logic [31:0] rl, input logic [3:0] flg,
                                input logic [31:0] ea, es, eil, edl);
        vec_t r;
        r.req = req; r.ia = ia; r.da = da; r.ds = ds; r.rs = rs; r.rl = rl;
        r.flg = flg; r.ea = ea; r.es = es; r.eil = eil; r.edl = edl;
        v.push_back(r);
    endfunction

    task automatic check(input string name, input logic [159:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        {iren, dren, dwen} = 3'b000;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    endtask

    int exp_ic, exp_dc, exp_st, cyc;

    initial begin
        nrst = 1'b0;
        drive_idle();
        // instruction fetch, 2 BUSY cycles then ACCESS
        add(3'b100, 32'h40, 0, 0, 0, 0,            4'b1100, 0,     0, 0, 0);
        add(3'b100, 32'h40, 0, 0, 1, 0,            4'b1110, 32'h40, 0, 0, 0);
        add(3'b100, 32'h40, 0, 0, 1, 0,            4'b1110, 32'h40, 0, 0, 0);
        add(3'b100, 32'h40, 0, 0, 2, 32'h8C220004, 4'b1110, 32'h40, 0, 0, 0);
        add(3'b100, 32'h40, 0, 0, 0, 0,            4'b0100, 0, 0, 32'h8C220004, 0);
        add(3'b000, 32'h40, 0, 0, 0, 0,            4'b1100, 0, 0, 32'h8C220004, 0);
        // simultaneous write + fetch: write served first
        add(3'b101, 32'h80, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1100, 0, 0, 32'h8C220004, 0);
        add(3'b101, 32'h80, 32'h100, 32'hDEADBEEF, 2, 0, 4'b1101, 32'h100, 32'hDEADBEEF, 32'h8C220004, 0);
        add(3'b100, 32'h80, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1000, 0, 0, 32'h8C220004, 0);
        add(3'b100, 32'h80, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1100, 0, 0, 32'h8C220004, 0);
        add(3'b100, 32'h80, 32'h100, 32'hDEADBEEF, 2, 32'h11111111, 4'b1110, 32'h80, 0, 32'h8C220004, 0);
        add(3'b000, 32'h80, 0, 0, 0, 0,            4'b0100, 0, 0, 32'h11111111, 0);
        // data read: ERROR then retried ACCESS
        add(3'b010, 0, 32'h200, 0, 0, 0,           4'b1100, 0, 0, 32'h11111111, 0);
        add(3'b010, 0, 32'h200, 0, 3, 32'h5555,    4'b1110, 32'h200, 0, 32'h11111111, 0);
        add(3'b010, 0, 32'h200, 0, 0, 0,           4'b1100, 0, 0, 32'h11111111, 0);
        add(3'b010, 0, 32'h200, 0, 2, 32'h1234,    4'b1110, 32'h200, 0, 32'h11111111, 0);
        add(3'b000, 0, 32'h200, 0, 0, 0,           4'b1000, 0, 0, 32'h11111111, 32'h1234);
        add(3'b000, 0, 32'h200, 0, 0, 0,           4'b1100, 0, 0, 32'h11111111, 32'h1234);
        // fetch withdrawn while BUSY: strobe drops same cycle, no pulse
        add(3'b100, 32'h300, 0, 0, 0, 0,           4'b1100, 0, 0, 32'h11111111, 32'h1234);
        add(3'b100, 32'h300, 0, 0, 1, 0,           4'b1110, 32'h300, 0, 32'h11111111, 32'h1234);
        add(3'b000, 32'h300, 0, 0, 1, 0,           4'b1100, 32'h300, 0, 32'h11111111, 32'h1234);
        add(3'b000, 32'h300, 0, 0, 2, 32'hFFFF,    4'b1100, 0, 0, 32'h11111111, 32'h1234);
        // read switches to write mid-grant: no dload capture
        add(3'b010, 0, 32'h400, 32'hA5A5, 0, 0,    4'b1100, 0, 0, 32'h11111111, 32'h1234);
        add(3'b010, 0, 32'h400, 32'hA5A5, 1, 0,    4'b1110, 32'h400, 32'hA5A5, 32'h11111111, 32'h1234);
        add(3'b011, 0, 32'h400, 32'hA5A5, 1, 0,    4'b1101, 32'h400, 32'hA5A5, 32'h11111111, 32'h1234);
        add(3'b011, 0, 32'h400, 32'hA5A5, 2, 32'h9999, 4'b1101, 32'h400, 32'hA5A5, 32'h11111111, 32'h1234);
        add(3'b000, 0, 32'h400, 32'hA5A5, 0, 0,    4'b1000, 0, 0, 32'h11111111, 32'h1234);
        // data arriving during an instruction grant does not preempt it
        add(3'b100, 32'h500, 0, 0, 0, 0,           4'b1100, 0, 0, 32'h11111111, 32'h1234);
        add(3'b110, 32'h500, 32'h600, 0, 2, 32'hCAFE, 4'b1110, 32'h500, 0, 32'h11111111, 32'h1234);
        add(3'b010, 32'h500, 32'h600, 0, 0, 0,     4'b0100, 0, 0, 32'hCAFE, 32'h1234);
        add(3'b010, 32'h500, 32'h600, 0, 0, 0,     4'b1100, 0, 0, 32'hCAFE, 32'h1234);
        add(3'b010, 32'h500, 32'h600, 0, 2, 32'hBEEF, 4'b1110, 32'h600, 0, 32'hCAFE, 32'h1234);
        add(3'b000, 32'h500, 32'h600, 0, 0, 0,     4'b1000, 0, 0, 32'hCAFE, 32'hBEEF);

        #12;
        check("reset", {96'd0, iwait, dwait, ramren, ramwen, ramaddr, iload, dload[27:0]},
              {96'd0, 4'b1100, 32'd0, 32'd0, 28'd0});
        @(negedge clk);
        nrst = 1'b1;
        exp_ic = 0; exp_dc = 0; exp_st = 0;
        foreach (v[k]) begin
            @(negedge clk);
            {iren, dren, dwen} = v[k].req;
            iaddr = v[k].ia; daddr = v[k].da; dstore = v[k].ds;
            ramstate = v[k].rs; ramload = v[k].rl;
            #1;
            check($sformatf("row%0d", k),
                  {iwait, dwait, ramren, ramwen, 28'd0, ramaddr, ramstore, iload, dload},
                  {v[k].flg, 28'd0, v[k].ea, v[k].es, v[k].eil, v[k].edl});
            exp_ic += int'(!v[k].flg[3]);
            exp_dc += int'(!v[k].flg[2]);
            exp_st += int'((v[k].req[2] & v[k].flg[3]) | ((v[k].req[1] | v[k].req[0]) & v[k].flg[2]));
        end
`ifdef ARB_STATS_EN
        @(negedge clk);
        drive_idle();
        check("icount", {128'd0, icount}, {128'd0, 32'(exp_ic)});
        check("dcount", {128'd0, dcount}, {128'd0, 32'(exp_dc)});
        check("stallcnt", {128'd0, stallcnt}, {128'd0, 32'(exp_st)});
`endif
        // minimum latency: RAM always ACCESS -> iwait low 2 cycles after request
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        iren = 1'b1; iaddr = 32'h700; ramstate = 2'd2; ramload = 32'h77;
        cyc = 0;
        #1;
        while (iwait && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("latency", {128'd0, 32'(cyc)}, {128'd0, 32'd2});
        check("latency_load", {128'd0, iload}, {128'd0, 32'h77});
        // asynchronous reset in the middle of a data write grant
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        dwen = 1'b1; daddr = 32'h800; dstore = 32'h42; ramstate = 2'd1;
        @(negedge clk);
        #1;
        check("dgrant_wen", {158'd0, ramwen, ramren}, {158'd0, 2'b10});
        nrst = 1'b0;
        #1;
        check("reset_mid", {iwait, dwait, ramren, ramwen, 28'd0, ramaddr, ramstore, iload, dload},
              {4'b1100, 28'd0, 32'd0, 32'd0, 32'd0, 32'd0});
        @(negedge clk);
        drive_idle();
        nrst = 1'b1;
        @(negedge clk);
        #1;
        check("after_reset", {156'd0, iwait, dwait, ramren, ramwen}, {156'd0, 4'b1100});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
